// File: rtl/acc_packer.sv
// Word packer: collects up to k words of W = m+n bits into a bit-sliced frame
// (bit b of word j at dout[b*k + j]) and holds it with pl high until acc_ready.
module acc_packer #(
  parameter int m = 3,
  parameter int n = 2,
  parameter int k = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [m+n-1:0]           in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     acc_ready,
  output logic                     pl,
  output logic [(m+n)*k-1:0]       dout,
  output logic [$clog2(k):0]       count
);

  localparam int W  = m + n;
  localparam int CW = $clog2(k) + 1;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count_next;
  logic [W*k-1:0]  dout_next;
  logic            accept;

  assign in_ready = (state == FILL);
  assign pl       = (state == FULL);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FILL;
      count <= '0;
      dout  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      dout  <= dout_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    dout_next  = dout;
    case (state)
      FILL: begin
        if (accept) begin
          // count is the slot index j of the incoming word
          for (int unsigned b = 0; b < W; b++) begin
            for (int unsigned j = 0; j < k; j++) begin
              if (count == CW'(j)) dout_next[b*k + j] = in_data[b];
            end
          end
          count_next = count + CW'(1);
          if (count == CW'(k - 1) || in_last) state_next = FULL;
        end
      end
      FULL: begin
        if (acc_ready) begin
          state_next = FILL;
          count_next = '0;
          dout_next  = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

endmodule

// File: tb/tb_acc_packer.sv
// Scoreboard bench for acc_packer at k=4, m=3, n=2: frames are modelled and
// queued as words are driven, then popped and compared when pl rises.
module tb_acc_packer;

  localparam int M  = 3;
  localparam int N  = 2;
  localparam int K  = 4;
  localparam int W  = M + N;
  localparam int CW = $clog2(K) + 1;

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_last;
  logic              in_ready;
  logic              acc_ready;
  logic              pl;
  logic [W*K-1:0]    dout;
  logic [CW-1:0]     count;

  int tests  = 0;
  int errors = 0;

  logic [W*K-1:0] q_dout[$];
  int             q_cnt[$];
  logic [W-1:0]   mwords[K];
  int             mcnt = 0;

  acc_packer #(.m(M), .n(N), .k(K)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .acc_ready(acc_ready),
    .pl(pl), .dout(dout), .count(count)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W*K-1:0] pack(input int cnt);
    logic [W*K-1:0] r;
    logic [W-1:0]   w;
    r = '0;
    for (int j = 0; j < cnt; j++) begin
      w = mwords[j];
      for (int b = 0; b < W; b++) r[b*K + j] = w[b];
    end
    return r;
  endfunction

  // Called at a negedge; word is accepted on the following posedge.
  task automatic send(input logic [W-1:0] d, input logic last);
    check("in_ready_on_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mwords[mcnt] = d;
    mcnt++;
    if (last || mcnt == K) begin
      q_dout.push_back(pack(mcnt));
      q_cnt.push_back(mcnt);
      mcnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_frame(output logic [W*K-1:0] ed, output int ec);
    int i;
    i  = 0;
    ed = '0;
    ec = 0;
    while (!pl && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!pl) begin
      check("pl_timeout", 32'(pl), 32'd1);
    end else if (q_dout.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      ed = q_dout.pop_front();
      ec = q_cnt.pop_front();
      check("frame_dout", 32'(dout), 32'(ed));
      check("frame_count", 32'(count), 32'(ec));
      check("frame_in_ready", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic expect_cleared(input string tag);
    check({tag, "_pl"}, 32'(pl), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W*K-1:0] ed;
    int             ec;
    logic [W-1:0]   rd;
    int             len;

    rstn = 1'b0;
    acc_ready = 1'b1;
    idle();
    #3;
    expect_cleared("reset_noclk");
    clk_en = 1'b1;
    @(negedge clk);
    rstn = 1'b1;

    // Full frame, back-to-back, transfer immediately
    for (int j = 0; j < K; j++) begin
      check("fill_count", 32'(count), 32'(j));
      send(W'(j + 1), 1'b0);
    end
    idle();
    check("pl_next_cycle", 32'(pl), 32'd1);
    wait_frame(ed, ec);
    check("frame1_const", 32'(dout), 32'h00865);
    @(negedge clk);
    expect_cleared("after_xfer1");

    // Held frame under backpressure while a word is offered
    acc_ready = 1'b0;
    send(5'd5, 1'b0); send(5'd10, 1'b0); send(5'd17, 1'b0); send(5'd30, 1'b0);
    in_valid = 1'b1; in_data = 5'd31; in_last = 1'b0;
    wait_frame(ed, ec);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_pl", 32'(pl), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_dout", 32'(dout), 32'(ed));
      check("hold_count", 32'(count), 32'(ec));
    end
    acc_ready = 1'b1;
    idle();
    @(negedge clk);
    expect_cleared("after_hold");

    // Short frame via in_last
    send(5'd7, 1'b0); send(5'd9, 1'b1);
    idle();
    check("short_pl_next", 32'(pl), 32'd1);
    wait_frame(ed, ec);
    check("short_const", 32'(dout), 32'h02113);
    @(negedge clk);

    // in_last on final slot acts as a plain full frame
    send(5'd3, 1'b0); send(5'd12, 1'b0); send(5'd25, 1'b0); send(5'd16, 1'b1);
    idle();
    wait_frame(ed, ec);
    @(negedge clk);

    // Reset mid-frame discards partial data
    send(5'd21, 1'b0); send(5'd14, 1'b0);
    idle();
    #2 rstn = 1'b0;
    mcnt = 0;
    #1;
    expect_cleared("reset_mid");
    @(negedge clk);
    rstn = 1'b1;
    send(5'd1, 1'b0); send(5'd2, 1'b0); send(5'd3, 1'b0); send(5'd4, 1'b0);
    idle();
    wait_frame(ed, ec);
    check("post_reset_const", 32'(dout), 32'h00865);
    @(negedge clk);

    // in_valid held across the transfer edge: next word lands at j=0 a cycle later
    send(5'd11, 1'b0); send(5'd22, 1'b0); send(5'd13, 1'b0); send(5'd8, 1'b0);
    in_valid = 1'b1; in_data = 5'd6; in_last = 1'b1;
    wait_frame(ed, ec);
    @(negedge clk);
    check("xfer_edge_count", 32'(count), 32'd0);
    check("xfer_edge_pl", 32'(pl), 32'd0);
    send(5'd6, 1'b1);
    idle();
    wait_frame(ed, ec);
    check("j0_const", 32'(dout), 32'h00110);
    @(negedge clk);

    // A few random-length frames
    for (int f = 0; f < 4; f++) begin
      len = int'($urandom_range(1, K));
      for (int j = 0; j < len; j++) begin
        rd = W'($urandom);
        send(rd, (j == len - 1));
      end
      idle();
      wait_frame(ed, ec);
      @(negedge clk);
    end

    check("sb_drained", 32'(q_dout.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
